// File: rtl/mcp4921_pkg.sv
// rtl/mcp4921_pkg.sv - shared types, command layout and frame timing for the MCP4921 streamer
// Purpose: FSM state enum, MCP4921 command bit positions, command builder and
//          frame-length function shared by the streamer and its helpers.
// Ports:   none (package).
package mcp4921_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CS_SETUP = 3'd1,
    ST_SHIFT    = 3'd2,
    ST_CS_HOLD  = 3'd3,
    ST_LDAC     = 3'd4
  } state_t;

  localparam int CMD_WIDTH    = 16;
  localparam int DAC_BITS     = 12;
  localparam int CMD_AB_BIT   = 15;
  localparam int CMD_BUF_BIT  = 14;
  localparam int CMD_GA_BIT   = 13;
  localparam int CMD_SHDN_BIT = 12;

  // CS setup + 16 bits of two half-periods each + CS hold + LDAC strobe.
  function automatic int frame_len(input int h);
    return h * (2 + 2 * CMD_WIDTH + 1);
  endfunction

  // Channel A is the only channel on the MCP4921, so the A/B bit stays 0.
  function automatic logic [CMD_WIDTH-1:0] build_cmd(
    input logic                buf_bit,
    input logic                ga_bit,
    input logic                shdn_bit,
    input logic [DAC_BITS-1:0] code
  );
    logic [CMD_WIDTH-1:0] cmd;
    cmd                 = '0;
    cmd[CMD_AB_BIT]     = 1'b0;
    cmd[CMD_BUF_BIT]    = buf_bit;
    cmd[CMD_GA_BIT]     = ga_bit;
    cmd[CMD_SHDN_BIT]   = shdn_bit;
    cmd[DAC_BITS-1:0]   = code;
    return cmd;
  endfunction

endpackage

// File: rtl/mcp4921_spi_s_axis_sample_tick_gen.sv
// rtl/mcp4921_spi_s_axis_sample_tick_gen.sv - free-running DAC sample-rate tick
// Purpose: one-clock tick every FCLK/FSMPL clocks, first tick when the counter
//          reaches FCLK/FSMPL-1 after reset release.
// Ports:   clk   - system clock
//          rst_n - asynchronous active-low reset (counter forced to 0)
//          tick  - one-clock sample strobe
module sample_tick_gen #(
  parameter real FCLK  = 100e6,
  parameter int  FSMPL = 200
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int PERIOD = int'(FCLK / FSMPL);
  localparam int CW     = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = (cnt_q == LAST);
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mcp4921_spi_s_axis.sv
// rtl/mcp4921_spi_s_axis.sv - AXI-Stream sample sink driving an MCP4921 DAC over SPI
// Purpose: holds one sample, and on every sample tick ships it to the DAC as a
//          16-bit SPI mode-0 frame followed by an LDAC strobe. Tracks packet
//          framing and missed ticks in sticky error flags.
// Ports:   clk, rst_n                 - clock, asynchronous active-low reset
//          s_axis_tdata/tvalid/tlast  - sample stream in, [11:0] is the DAC code
//          s_axis_tready              - high while the holding register is empty
//          cs, sck, mosi, ldac        - MCP4921 pins (cs/ldac active low)
//          err_clr                    - synchronous clear of underrun/pkt_err
//          underrun                   - sticky: tick found no sample to send
//          pkt_err                    - sticky: tlast not on beat SMPLS
module mcp4921_spi_s_axis
  import mcp4921_pkg::*;
#(
  parameter real FCLK       = 100e6,
  parameter int  FSMPL      = 200,
  parameter real FSCK       = 1e6,
  parameter bit  BUF        = 1'b0,
  parameter bit  GA         = 1'b1,
  parameter bit  SHDN       = 1'b1,
  parameter int  SMPLS      = 30,
  parameter int  DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  output logic                  cs,
  output logic                  sck,
  output logic                  mosi,
  output logic                  ldac,
  input  logic                  err_clr,
  output logic                  underrun,
  output logic                  pkt_err
);

  localparam int H      = int'(FCLK / (2.0 * FSCK));
  localparam int PERIOD = int'(FCLK / FSMPL);
  localparam int FRAME  = frame_len(H);
  localparam int HW     = (H > 1) ? $clog2(H) : 1;
  localparam int BW     = $clog2(SMPLS + 1);
  localparam logic [HW-1:0] H_LAST   = HW'(H - 1);
  localparam logic [BW-1:0] BEAT_MAX = BW'(SMPLS);

  // A frame that does not finish before the next tick would drop every other sample.
  if (FRAME >= PERIOD) begin : g_frame_too_long
    $error("mcp4921_spi_s_axis: frame length does not fit in one sample period");
  end
  if (H < 1) begin : g_sck_too_fast
    $error("mcp4921_spi_s_axis: FSCK too high for FCLK");
  end

  if (DATA_WIDTH > DAC_BITS) begin : g_unused_upper
    logic unused_upper;
    assign unused_upper = ^s_axis_tdata[DATA_WIDTH-1:DAC_BITS];
  end

  logic tick;

  sample_tick_gen #(
    .FCLK  (FCLK),
    .FSMPL (FSMPL)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  state_t                state_q, state_d;
  logic [HW-1:0]         hcnt_q, hcnt_d;
  logic [3:0]            bit_q, bit_d;
  logic                  sck_q, sck_d;
  logic [CMD_WIDTH-1:0]  shift_q, shift_d;
  logic                  cs_q, ldac_q;
  logic                  full_q, full_d;
  logic [DAC_BITS-1:0]   data_q, data_d;
  logic                  rdy_q;
  logic [BW-1:0]         beat_q, beat_d;
  logic                  underrun_q, underrun_d;
  logic                  pkt_err_q, pkt_err_d;
  logic                  load;
  logic                  tick_lost;
  logic                  hdone;
  logic                  accept;
  logic                  bad_beat;

  assign s_axis_tready = rdy_q & ~full_q;
  assign accept        = s_axis_tvalid & s_axis_tready;

  // Frame sequencer.
  always_comb begin
    state_d   = state_q;
    hcnt_d    = hcnt_q;
    bit_d     = bit_q;
    sck_d     = sck_q;
    shift_d   = shift_q;
    load      = 1'b0;
    tick_lost = 1'b0;
    hdone     = (hcnt_q == H_LAST);

    case (state_q)
      ST_IDLE: begin
        if (tick) begin
          if (full_q) begin
            load    = 1'b1;
            shift_d = build_cmd(BUF, GA, SHDN, data_q);
            hcnt_d  = '0;
            state_d = ST_CS_SETUP;
          end else begin
            tick_lost = 1'b1;
          end
        end
      end
      ST_CS_SETUP: begin
        if (hdone) begin
          hcnt_d  = '0;
          bit_d   = '0;
          sck_d   = 1'b0;
          state_d = ST_SHIFT;
        end else begin
          hcnt_d = hcnt_q + 1'b1;
        end
      end
      ST_SHIFT: begin
        if (hdone) begin
          hcnt_d = '0;
          if (!sck_q) begin
            sck_d = 1'b1;
          end else begin
            // Data advances only on the falling SCK edge so it is stable at the rise.
            sck_d   = 1'b0;
            shift_d = {shift_q[CMD_WIDTH-2:0], 1'b0};
            if (bit_q == 4'd15) begin
              state_d = ST_CS_HOLD;
            end else begin
              bit_d = bit_q + 4'd1;
            end
          end
        end else begin
          hcnt_d = hcnt_q + 1'b1;
        end
      end
      ST_CS_HOLD: begin
        if (hdone) begin
          hcnt_d  = '0;
          state_d = ST_LDAC;
        end else begin
          hcnt_d = hcnt_q + 1'b1;
        end
      end
      ST_LDAC: begin
        if (hdone) begin
          hcnt_d  = '0;
          state_d = ST_IDLE;
        end else begin
          hcnt_d = hcnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        hcnt_d  = '0;
        sck_d   = 1'b0;
      end
    endcase

    if (tick && (state_q != ST_IDLE)) begin
      tick_lost = 1'b1;
    end
  end

  // Holding register, packet beat counter and sticky flags.
  always_comb begin
    full_d     = full_q;
    data_d     = data_q;
    beat_d     = beat_q;
    bad_beat   = 1'b0;
    underrun_d = underrun_q;
    pkt_err_d  = pkt_err_q;

    if (load) begin
      full_d = 1'b0;
    end else if (accept) begin
      full_d = 1'b1;
    end
    if (accept) begin
      data_d = s_axis_tdata[DAC_BITS-1:0];
    end

    if (accept) begin
      bad_beat = (s_axis_tlast != (beat_q == BEAT_MAX));
      if (s_axis_tlast || (beat_q == BEAT_MAX)) begin
        beat_d = BW'(1);
      end else begin
        beat_d = beat_q + 1'b1;
      end
    end

    // Set has priority over clear.
    if (err_clr) begin
      underrun_d = 1'b0;
      pkt_err_d  = 1'b0;
    end
    if (tick_lost) begin
      underrun_d = 1'b1;
    end
    if (bad_beat) begin
      pkt_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      hcnt_q     <= '0;
      bit_q      <= '0;
      sck_q      <= 1'b0;
      shift_q    <= '0;
      cs_q       <= 1'b1;
      ldac_q     <= 1'b1;
      full_q     <= 1'b0;
      data_q     <= '0;
      rdy_q      <= 1'b0;
      beat_q     <= BW'(1);
      underrun_q <= 1'b0;
      pkt_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      hcnt_q     <= hcnt_d;
      bit_q      <= bit_d;
      sck_q      <= sck_d;
      shift_q    <= shift_d;
      // Pin levels are registered from the next state so they never glitch.
      cs_q       <= ~((state_d == ST_CS_SETUP) || (state_d == ST_SHIFT) ||
                      (state_d == ST_CS_HOLD));
      ldac_q     <= (state_d != ST_LDAC);
      full_q     <= full_d;
      data_q     <= data_d;
      rdy_q      <= 1'b1;
      beat_q     <= beat_d;
      underrun_q <= underrun_d;
      pkt_err_q  <= pkt_err_d;
    end
  end

  assign cs       = cs_q;
  assign sck      = sck_q;
  assign mosi     = shift_q[CMD_WIDTH-1];
  assign ldac     = ldac_q;
  assign underrun = underrun_q;
  assign pkt_err  = pkt_err_q;

endmodule

// File: tb/tb_mcp4921_spi_s_axis.sv
// tb/tb_mcp4921_spi_s_axis.sv - self-checking bench for mcp4921_spi_s_axis
module tb_mcp4921_spi_s_axis;

  localparam real FCLK   = 10e6;
  localparam int  FSMPL  = 25000;
  localparam real FSCK   = 1e6;
  localparam int  H      = 5;
  localparam int  PER    = 400;
  localparam int  SMPLS  = 30;
  localparam int  CS_LOW = 34 * H;
  // A/B=0, BUF=0, GA=1, SHDN=1
  localparam logic [3:0] CMD_HI = 4'b0011;

  typedef struct {
    logic [15:0] word;
    int          nbits;
    int          cs_len;
    int          ldac_len;
    int          start;
    int          unstable;
  } frame_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] s_axis_tdata = '0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tlast = 1'b0;
  logic        s_axis_tready;
  logic        cs, sck, mosi, ldac;
  logic        err_clr = 1'b0;
  logic        underrun, pkt_err;

  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          rel = 0;
  int          cs_falls = 0;
  logic [15:0] sb[$];
  frame_t      frames[$];

  mcp4921_spi_s_axis #(
    .FCLK       (FCLK),
    .FSMPL      (FSMPL),
    .FSCK       (FSCK),
    .BUF        (1'b0),
    .GA         (1'b1),
    .SHDN       (1'b1),
    .SMPLS      (SMPLS),
    .DATA_WIDTH (16)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .cs            (cs),
    .sck           (sck),
    .mosi          (mosi),
    .ldac          (ldac),
    .err_clr       (err_clr),
    .underrun      (underrun),
    .pkt_err       (pkt_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // Pin monitor: decodes each SPI frame and the LDAC strobe that follows it.
  initial begin
    frame_t mon;
    bit     in_frame = 0;
    bit     in_ldac = 0;
    logic   cs_p = 1'b1;
    logic   sck_p = 1'b0;
    logic   hold = 1'b0;
    mon = '{default: 0};
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_frame = 0;
        in_ldac  = 0;
      end else begin
        if (cs_p && !cs) cs_falls++;
        if (in_frame && cs) begin
          in_frame     = 0;
          in_ldac      = 1;
          mon.ldac_len = 0;
        end
        if (in_ldac) begin
          if (!ldac) mon.ldac_len++;
          else begin
            frames.push_back(mon);
            in_ldac = 0;
          end
        end
        if (!in_frame && !in_ldac && cs_p && !cs) begin
          in_frame     = 1;
          mon.start    = cyc;
          mon.cs_len   = 0;
          mon.word     = '0;
          mon.nbits    = 0;
          mon.unstable = 0;
        end
        if (in_frame) begin
          mon.cs_len++;
          if (sck && !sck_p) begin
            mon.word = {mon.word[14:0], mosi};
            mon.nbits++;
            hold = mosi;
          end else if (sck && sck_p && (mosi !== hold)) begin
            mon.unstable++;
          end
        end
      end
      cs_p  = cs;
      sck_p = sck;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n         = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    err_clr       = 1'b0;
    repeat (3) @(negedge clk);
    sb.delete();
    frames.delete();
    rst_n = 1'b1;
    rel   = cyc;
  endtask

  task automatic send_beat(input logic [15:0] d, input bit last, input bit rnd,
                           output int acc_cyc);
    bit done = 0;
    acc_cyc = -1;
    for (int n = 0; n < 2000 && !done; n++) begin
      @(negedge clk);
      s_axis_tvalid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      s_axis_tdata  = d;
      s_axis_tlast  = last;
      if (s_axis_tvalid && s_axis_tready) begin
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        done    = 1;
        sb.push_back({CMD_HI, d[11:0]});
      end
    end
    chk("beat_accepted", {31'd0, done}, 32'd1);
  endtask

  task automatic check_frame(input string tag, input int exp_start);
    frame_t      f;
    bit          ok = 0;
    logic [15:0] e;
    for (int n = 0; n < 3000 && !ok; n++) begin
      if (frames.size() > 0) ok = 1;
      else @(negedge clk);
    end
    chk({tag, "_present"}, {31'd0, ok}, 32'd1);
    if (ok) begin
      f = frames.pop_front();
      e = (sb.size() > 0) ? sb.pop_front() : 16'hxxxx;
      chk({tag, "_word"}, {16'd0, f.word}, {16'd0, e});
      chk({tag, "_nbits"}, f.nbits, 16);
      chk({tag, "_cs_len"}, f.cs_len, CS_LOW);
      chk({tag, "_ldac_len"}, f.ldac_len, H);
      chk({tag, "_mosi_stable"}, f.unstable, 0);
      if (exp_start >= 0) chk({tag, "_start"}, f.start, exp_start);
    end
  endtask

  initial begin
    int          a;
    int          acc[4];
    int          falls0;
    bit          found;
    logic [15:0] d;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_cs", {31'd0, cs}, 32'd1);
    chk("rst_sck", {31'd0, sck}, 32'd0);
    chk("rst_mosi", {31'd0, mosi}, 32'd0);
    chk("rst_ldac", {31'd0, ldac}, 32'd1);
    chk("rst_tready", {31'd0, s_axis_tready}, 32'd0);
    chk("rst_underrun", {31'd0, underrun}, 32'd0);
    chk("rst_pkt_err", {31'd0, pkt_err}, 32'd0);
    rst_n = 1'b1;
    rel   = cyc;
    @(posedge clk);
    #1;
    chk("tready_clk1", {31'd0, s_axis_tready}, 32'd1);

    // Single sample 0x0ABC
    send_beat(16'h0ABC, 1'b0, 1'b0, a);
    s_axis_tvalid = 1'b0;
    check_frame("abc", rel + PER);
    chk("abc_underrun", {31'd0, underrun}, 32'd0);
    chk("abc_pkt_err", {31'd0, pkt_err}, 32'd0);

    // Full packet with random tvalid gaps
    do_reset();
    for (int i = 0; i < SMPLS; i++) begin
      d = 16'($urandom);
      send_beat(d, (i == SMPLS - 1), 1'b1, a);
    end
    s_axis_tvalid = 1'b0;
    for (int i = 0; i < SMPLS; i++) check_frame("pkt", rel + PER * (i + 1));
    chk("pkt_pkt_err", {31'd0, pkt_err}, 32'd0);
    chk("pkt_underrun", {31'd0, underrun}, 32'd0);

    // Early tlast, set-over-clear priority, clear, counter restart
    do_reset();
    for (int i = 0; i < 28; i++) send_beat(16'(i * 3 + 16'h100), 1'b0, 1'b0, a);
    chk("early_no_err_yet", {31'd0, pkt_err}, 32'd0);
    err_clr = 1'b1;
    send_beat(16'h0777, 1'b1, 1'b0, a);
    chk("early_pkt_err_set", {31'd0, pkt_err}, 32'd1);
    s_axis_tvalid = 1'b0;
    @(posedge clk);
    #1;
    chk("early_pkt_err_clr", {31'd0, pkt_err}, 32'd0);
    err_clr = 1'b0;
    for (int i = 0; i < SMPLS; i++) send_beat(16'(16'h0200 + i), (i == SMPLS - 1), 1'b0, a);
    s_axis_tvalid = 1'b0;
    chk("restart_pkt_err", {31'd0, pkt_err}, 32'd0);
    for (int i = 0; i < 28 + 1 + SMPLS; i++) check_frame("early", -1);

    // Underrun and upper-bit masking
    do_reset();
    falls0 = cs_falls;
    repeat (PER + 20) @(negedge clk);
    chk("urun_no_cs", cs_falls - falls0, 0);
    chk("urun_set", {31'd0, underrun}, 32'd1);
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    chk("urun_clr", {31'd0, underrun}, 32'd0);
    err_clr = 1'b0;
    send_beat(16'hF123, 1'b0, 1'b0, a);
    s_axis_tvalid = 1'b0;
    check_frame("upper", rel + 2 * PER);

    // Reset during SHIFT bit 7
    do_reset();
    send_beat(16'h0555, 1'b0, 1'b0, a);
    s_axis_tvalid = 1'b0;
    found = 0;
    for (int n = 0; n < 1000 && !found; n++) begin
      @(negedge clk);
      if (!cs) found = 1;
    end
    chk("abort_cs_seen", {31'd0, found}, 32'd1);
    repeat (92) @(negedge clk);
    chk("abort_sck_high", {31'd0, sck}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_cs", {31'd0, cs}, 32'd1);
    chk("abort_sck", {31'd0, sck}, 32'd0);
    chk("abort_ldac", {31'd0, ldac}, 32'd1);
    repeat (3) @(negedge clk);
    sb.delete();
    rst_n = 1'b1;
    rel   = cyc;
    @(posedge clk);
    #1;
    chk("abort_tready_clk1", {31'd0, s_axis_tready}, 32'd1);
    falls0 = cs_falls;
    repeat (PER + 50) @(negedge clk);
    chk("abort_no_frame", cs_falls - falls0, 0);
    chk("abort_no_record", frames.size(), 0);
    send_beat(16'h0777, 1'b0, 1'b0, a);
    s_axis_tvalid = 1'b0;
    check_frame("after_abort", rel + 2 * PER);

    // Continuous tvalid: one beat per frame, order preserved
    do_reset();
    for (int i = 0; i < 4; i++) begin
      send_beat(16'(16'h0A10 + i * 16'h111), 1'b0, 1'b0, acc[i]);
      @(negedge clk);
      chk("cont_tready_full", {31'd0, s_axis_tready}, 32'd0);
    end
    s_axis_tvalid = 1'b0;
    chk("cont_acc0", acc[0], rel + 2);
    chk("cont_acc1", acc[1], rel + PER + 1);
    chk("cont_acc2", acc[2] - acc[1], PER);
    chk("cont_acc3", acc[3] - acc[2], PER);
    for (int i = 0; i < 4; i++) check_frame("cont", rel + PER * (i + 1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
